// File: rtl/fc2_relu_seq.sv
// fc2_relu_seq: 4-to-8 fully connected expansion with bias, ReLU and saturation,
// time-multiplexed over one multiplier (one product per cycle, S7.8 fixed point).
`default_nettype none

module fc2_relu_seq #(
    parameter int IN_DIM          = 4,
    parameter int OUT_DIM         = 8,
    parameter int FRACTIONAL_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic signed [15:0] i_x [0:IN_DIM-1],
    output logic               o_busy,
    output logic               o_done_tick,
    output logic signed [15:0] o_y [0:OUT_DIM-1]
);

    localparam int IW = $clog2(OUT_DIM);
    localparam int JW = $clog2(IN_DIM);
    localparam logic [IW-1:0] LAST_I = IW'(OUT_DIM - 1);
    localparam logic [JW-1:0] LAST_J = JW'(IN_DIM - 1);

    // W[i][j] = 32*(j+1) - 24*i
    localparam logic signed [15:0] W_ROM [0:OUT_DIM-1][0:IN_DIM-1] = '{
        '{ 16'sd32,    16'sd64,    16'sd96,   16'sd128},
        '{ 16'sd8,     16'sd40,    16'sd72,   16'sd104},
        '{-16'sd16,    16'sd16,    16'sd48,   16'sd80 },
        '{-16'sd40,   -16'sd8,     16'sd24,   16'sd56 },
        '{-16'sd64,   -16'sd32,    16'sd0,    16'sd32 },
        '{-16'sd88,   -16'sd56,   -16'sd24,   16'sd8  },
        '{-16'sd112,  -16'sd80,   -16'sd48,  -16'sd16 },
        '{-16'sd136,  -16'sd104,  -16'sd72,  -16'sd40 }
    };

    localparam logic signed [15:0] B_ROM [0:OUT_DIM-1] = '{
        16'sd1, 16'sd3, 16'sd5, 16'sd7, 16'sd9, 16'sd11, 16'sd13, 16'sd15
    };

    localparam logic signed [31:0] ROUND_HALF = 32'sd1 <<< (FRACTIONAL_BITS - 1);
    localparam logic signed [31:0] SAT_MAX    = 32'sd32767;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [15:0] x_q [0:IN_DIM-1];
    logic [IW-1:0]      i_idx;
    logic [JW-1:0]      j_idx;
    logic signed [31:0] acc;

    logic signed [31:0] x_ext;
    logic signed [31:0] w_ext;
    logic signed [31:0] product;
    logic signed [31:0] term;
    logic signed [31:0] sum;
    logic signed [15:0] sat_val;

    // Round-half-up rescale of the S15.16 product back to S7.8
    assign x_ext   = 32'(x_q[j_idx]);
    assign w_ext   = 32'(W_ROM[i_idx][j_idx]);
    assign product = x_ext * w_ext;
    assign term    = (product + ROUND_HALF) >>> FRACTIONAL_BITS;
    assign sum     = acc + 32'(B_ROM[i_idx]);

    always_comb begin
        sat_val = sum[15:0];
        if (sum < 32'sd0) begin
            sat_val = 16'sd0;
        end else if (sum > SAT_MAX) begin
            sat_val = 16'sd32767;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_busy      = 1'b1;
        o_done_tick = 1'b0;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (j_idx == LAST_J) begin
                    state_nxt = S_FINAL;
                end
            end
            S_FINAL: begin
                state_nxt = (i_idx == LAST_I) ? S_DONE : S_MAC;
            end
            S_DONE: begin
                o_done_tick = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            i_idx <= '0;
            j_idx <= '0;
            acc   <= '0;
            for (int k = 0; k < IN_DIM; k++) begin
                x_q[k] <= '0;
            end
            for (int k = 0; k < OUT_DIM; k++) begin
                o_y[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    // Capture so later changes on i_x cannot disturb this run
                    if (i_start) begin
                        for (int k = 0; k < IN_DIM; k++) begin
                            x_q[k] <= i_x[k];
                        end
                        i_idx <= '0;
                        j_idx <= '0;
                        acc   <= '0;
                    end
                end
                S_MAC: begin
                    acc <= acc + term;
                    if (j_idx != LAST_J) begin
                        j_idx <= j_idx + JW'(1);
                    end
                end
                S_FINAL: begin
                    o_y[i_idx] <= sat_val;
                    acc        <= '0;
                    j_idx      <= '0;
                    if (i_idx != LAST_I) begin
                        i_idx <= i_idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fc2_relu_seq.sv
// Self-checking bench for fc2_relu_seq: cycle-level behavioural model plus
// hand-computed expectations for the reset, rounding, saturation and handshake corners.
`default_nettype none

module tb_fc2_relu_seq;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [15:0] x [0:3];
    logic               busy;
    logic               done;
    logic signed [15:0] y [0:7];

    int total = 0;
    int bad   = 0;

    fc2_relu_seq #(
        .IN_DIM(4),
        .OUT_DIM(8),
        .FRACTIONAL_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(start),
        .i_x(x),
        .o_busy(busy),
        .o_done_tick(done),
        .o_y(y)
    );

    always #5 clk = ~clk;

    // Expected output i from the arithmetic definition of the layer
    function automatic int ref_y(input int x0, input int x1, input int x2, input int x3, input int i);
        int xs[4];
        int acc;
        int s;
        xs  = '{x0, x1, x2, x3};
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            acc += (xs[j] * (32 * (j + 1) - 24 * i) + 128) >>> 8;
        end
        s = acc + 2 * i + 1;
        if (s < 0) return 0;
        if (s > 32767) return 32767;
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timing model: a run accepted in idle lasts 41 cycles, done on the last one
    bit m_active = 1'b0;
    int m_cnt    = 0;
    int m_x [4]  = '{0, 0, 0, 0};
    int m_hold [8] = '{0, 0, 0, 0, 0, 0, 0, 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            for (int k = 0; k < 8; k++) m_hold[k] <= 0;
        end else if (!m_active && start) begin
            m_active <= 1'b1;
            m_cnt    <= 0;
            for (int k = 0; k < 4; k++) m_x[k] <= int'(x[k]);
        end else if (m_active) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 40) begin
                m_active <= 1'b0;
                for (int k = 0; k < 8; k++) m_hold[k] <= ref_y(m_x[0], m_x[1], m_x[2], m_x[3], k);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            bit m_done;
            m_done = m_active && (m_cnt == 40);
            check("busy", int'(busy), int'(m_active));
            check("done_tick", int'(done), int'(m_done));
            if (!m_active || m_done) begin
                for (int k = 0; k < 8; k++) begin
                    int e;
                    e = m_done ? ref_y(m_x[0], m_x[1], m_x[2], m_x[3], k) : m_hold[k];
                    check($sformatf("model_y[%0d]", k), int'(y[k]), e);
                end
            end
        end
    end

    task automatic set_x(input int a, input int b, input int c, input int d);
        x[0] = 16'(a);
        x[1] = 16'(b);
        x[2] = 16'(c);
        x[3] = 16'(d);
    endtask

    // Caller is just past the start edge E0; returns at the negedge of the done cycle
    task automatic wait_done(input bit scramble, output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int n = 0; n <= 60; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = n;
                break;
            end
            if (scramble) set_x($urandom, $urandom, $urandom, $urandom);
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done tick, expected one within 60 cycles");
        end
    endtask

    task automatic run(input int a, input int b, input int c, input int d, input bit scramble,
                       output int lat, output int busy_n);
        @(posedge clk);
        #2;
        set_x(a, b, c, d);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(scramble, lat, busy_n);
    endtask

    task automatic count_ticks(input int cycles, output int ticks);
        ticks = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (done) ticks++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int busy_n;
        int ticks;
        int t1;
        int t2;
        int exp321 [8];

        exp321 = '{321, 227, 133, 39, 0, 0, 0, 0};
        set_x(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        for (int k = 0; k < 8; k++) check($sformatf("reset_y[%0d]", k), int'(y[k]), 0);
        rst = 1'b0;

        run(256, 256, 256, 256, 1'b0, lat, busy_n);
        check("latency", lat, 40);
        check("busy_cycles", busy_n, 41);
        for (int k = 0; k < 8; k++) check($sformatf("basic_y[%0d]", k), int'(y[k]), exp321[k]);

        run(4, 0, 0, 0, 1'b0, lat, busy_n);
        check("round_4_y0", int'(y[0]), 2);
        run(1, 0, 0, 0, 1'b0, lat, busy_n);
        check("round_1_y0", int'(y[0]), 1);
        run(-4, 0, 0, 0, 1'b0, lat, busy_n);
        check("round_m4_y0", int'(y[0]), 1);

        run(32767, 32767, 32767, 32767, 1'b0, lat, busy_n);
        check("sat_y0", int'(y[0]), 32767);
        check("sat_y1", int'(y[1]), 28675);
        check("relu_y7", int'(y[7]), 0);

        // start held high: runs accepted at E0 and E42; released during the second run
        @(posedge clk);
        #2;
        set_x(256, 256, 256, 256);
        start = 1'b1;
        @(posedge clk);
        ticks = 0;
        t1 = -1;
        t2 = -1;
        for (int n = 0; n < 130; n++) begin
            @(negedge clk);
            if (done) begin
                ticks++;
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
            if (n == 45) start = 1'b0;
        end
        check("held_ticks", ticks, 2);
        check("held_first", t1, 40);
        check("held_second", t2, 82);
        check("held_idle_after", int'(busy), 0);

        // start during the done cycle must be dropped
        run(256, 0, 0, 0, 1'b0, lat, busy_n);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        count_ticks(50, ticks);
        check("done_cycle_start_ticks", ticks, 0);

        // back-to-back: raise start in the first idle cycle after done
        run(100, -200, 300, -400, 1'b0, lat, busy_n);
        @(posedge clk);
        #2;
        set_x(256, 256, 256, 256);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(1'b0, lat, busy_n);
        check("b2b_latency", lat, 40);
        check("b2b_y0", int'(y[0]), 321);

        // reset mid-run
        @(posedge clk);
        #2;
        set_x(1000, 2000, 3000, 4000);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        for (int k = 0; k < 8; k++) check($sformatf("midrst_y[%0d]", k), int'(y[k]), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        count_ticks(50, ticks);
        check("midrst_ticks", ticks, 0);
        run(256, 256, 256, 256, 1'b0, lat, busy_n);
        check("post_rst_latency", lat, 40);
        for (int k = 0; k < 8; k++) check($sformatf("post_rst_y[%0d]", k), int'(y[k]), exp321[k]);

        // vector produced by the upstream stage for z = {256,0,0,0}
        run(29, 133, 59, 36, 1'b0, lat, busy_n);
        check("chain_y0", int'(y[0]), 78);
        check("chain_y1", int'(y[1]), 57);
        for (int k = 0; k < 8; k++) check($sformatf("chain_y[%0d]", k), int'(y[k]), ref_y(29, 133, 59, 36, k));

        // random vectors, with i_x scrambled while the run is in flight
        for (int r = 0; r < 20; r++) begin
            run($urandom, $urandom, $urandom, $urandom, r[0], lat, busy_n);
            check("rand_latency", lat, 40);
        end
        for (int r = 0; r < 10; r++) begin
            run($urandom_range(1200, 0) - 600, $urandom_range(1200, 0) - 600,
                $urandom_range(1200, 0) - 600, $urandom_range(1200, 0) - 600, 1'b1, lat, busy_n);
            check("small_rand_latency", lat, 40);
        end
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
